// File: rtl/weight_mem_loader.sv
// Weight/delay memory loader: parses framed write commands from the input byte
// stream and drives the memory write port with auto-incrementing, wrapping addresses.
module weight_mem_loader #(
   parameter int          M          = 320,
   parameter int          N          = 8,
   parameter logic [7:0]  START_CODE = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   input  logic                   abort,
   output logic [$clog2(M)-1:0]   mem_addr,
   output logic [N-1:0]           mem_data,
   output logic                   mem_we,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int AW = $clog2(M);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_HI = 3'd1,
      ST_ADDR_LO = 3'd2,
      ST_LEN     = 3'd3,
      ST_DATA    = 3'd4
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [7:0]      addr_hi_r, addr_hi_nxt_s;
   logic [AW-1:0]   cur_addr_r, cur_addr_nxt_s;
   logic [7:0]      remaining_r, remaining_nxt_s;
   logic [AW-1:0]   mem_addr_r, mem_addr_nxt_s;
   logic [N-1:0]    mem_data_r, mem_data_nxt_s;
   logic            mem_we_r, mem_we_nxt_s;
   logic            done_r, done_nxt_s;
   logic            err_r, err_nxt_s;
   logic            rx_ready_r;
   logic            busy_s;
   logic            accept_s;
   logic [AW-1:0]   start_addr_s;
   logic            start_bad_s;

   // Address successor with wrap from the last word back to word 0.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      if (a == AW'(M - 1)) begin
         return {AW{1'b0}};
      end else begin
         return a + AW'(1);
      end
   endfunction

   assign busy_s       = (state_r != ST_IDLE);
   assign accept_s     = rx_valid && rx_ready_r;
   // Bits of ADDR_HI above the address width are dropped by the cast.
   assign start_addr_s = AW'({addr_hi_r, rx_data});
   assign start_bad_s  = (32'(start_addr_s) >= 32'(M));

   // Next-state and next-output decode; abort overrides any byte acceptance.
   always_comb begin
      state_nxt_s     = state_r;
      addr_hi_nxt_s   = addr_hi_r;
      cur_addr_nxt_s  = cur_addr_r;
      remaining_nxt_s = remaining_r;
      mem_addr_nxt_s  = mem_addr_r;
      mem_data_nxt_s  = mem_data_r;
      mem_we_nxt_s    = 1'b0;
      done_nxt_s      = 1'b0;
      err_nxt_s       = err_r;
      if (abort) begin
         state_nxt_s = ST_IDLE;
         if (busy_s) begin
            err_nxt_s = 1'b1;
         end else begin
            err_nxt_s = err_r;
         end
      end else if (accept_s) begin
         case (state_r)
            ST_IDLE: begin
               if (rx_data == START_CODE) begin
                  state_nxt_s = ST_ADDR_HI;
                  err_nxt_s   = 1'b0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ADDR_HI: begin
               addr_hi_nxt_s = rx_data;
               state_nxt_s   = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
               if (start_bad_s) begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  cur_addr_nxt_s = start_addr_s;
                  state_nxt_s    = ST_LEN;
               end
            end
            ST_LEN: begin
               remaining_nxt_s = rx_data;
               state_nxt_s     = ST_DATA;
            end
            ST_DATA: begin
               mem_we_nxt_s    = 1'b1;
               mem_addr_nxt_s  = cur_addr_r;
               mem_data_nxt_s  = N'(rx_data);
               cur_addr_nxt_s  = next_addr(cur_addr_r);
               remaining_nxt_s = remaining_r - 8'd1;
               if (remaining_r == 8'd0) begin
                  done_nxt_s  = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, counters and registered memory-port outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         addr_hi_r   <= 8'd0;
         cur_addr_r  <= {AW{1'b0}};
         remaining_r <= 8'd0;
         mem_addr_r  <= {AW{1'b0}};
         mem_data_r  <= {N{1'b0}};
         mem_we_r    <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         rx_ready_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         addr_hi_r   <= addr_hi_nxt_s;
         cur_addr_r  <= cur_addr_nxt_s;
         remaining_r <= remaining_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_data_r  <= mem_data_nxt_s;
         mem_we_r    <= mem_we_nxt_s;
         done_r      <= done_nxt_s;
         err_r       <= err_nxt_s;
         rx_ready_r  <= 1'b1;
      end
   end

   assign rx_ready = rx_ready_r;
   assign mem_addr = mem_addr_r;
   assign mem_data = mem_data_r;
   assign mem_we   = mem_we_r;
   assign done     = done_r;
   assign err      = err_r;
   assign busy     = busy_s;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: expected writes are queued as bytes are
// driven and compared in the cycle the write must appear.
module tb_weight_mem_loader;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       abort;
   logic [8:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_we;
   logic       busy;
   logic       done;
   logic       err;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   logic exp_pending;
   int   checks;
   int   errors;

   weight_mem_loader dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .abort    (abort),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_we   (mem_we),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_write(input int addr, input logic [7:0] data, input logic last);
      exp_t e;
      e.addr = 9'(addr);
      e.data = data;
      e.done = last;
      exp_q.push_back(e);
      exp_pending = 1'b1;
   endtask

   // One clock: present inputs, sample #1 after the edge, compare against the scoreboard.
   task automatic drive_cycle(input logic v, input logic [7:0] d, input logic ab);
      exp_t e;
      rx_valid = v;
      rx_data  = d;
      abort    = ab;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      abort    = 1'b0;
      if (exp_pending) begin
         e = exp_q.pop_front();
         checks++;
         if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_data !== e.data || done !== e.done) begin
            errors++;
            $display("FAIL write: got we=%b addr=%0d data=%h done=%b expected we=1 addr=%0d data=%h done=%b",
                     mem_we, mem_addr, mem_data, done, e.addr, e.data, e.done);
         end
      end else begin
         checks++;
         if (mem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_write: got we=%b done=%b addr=%0d expected we=0 done=0", mem_we, done, mem_addr);
         end
      end
      exp_pending = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      drive_cycle(1'b1, d, 1'b0);
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got %0d pending writes expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (mem_addr !== 9'd0 || mem_data !== 8'd0 || mem_we !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got addr=%0d data=%h we=%b done=%b err=%b busy=%b rdy=%b expected all 0",
                  mem_addr, mem_data, mem_we, done, err, busy, rx_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive_cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (rx_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_reset: got rdy=%b busy=%b expected rdy=1 busy=0", rx_ready, busy);
      end
   endtask

   task automatic test_basic();
      send(8'hA5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b expected 1", busy);
      end
      send(8'h00); send(8'h05); send(8'h02);
      push_write(5, 8'h11, 1'b0); send(8'h11);
      push_write(6, 8'h22, 1'b0); send(8'h22);
      push_write(7, 8'h33, 1'b1); send(8'h33);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: got busy=%b err=%b expected busy=0 err=0", busy, err);
      end
      drive_cycle(1'b0, 8'h00, 1'b0);
      check_drained("basic");
   endtask

   task automatic test_wrap();
      send(8'hA5); send(8'h01); send(8'h3F); send(8'h02);
      push_write(319, 8'hAA, 1'b0); send(8'hAA);
      push_write(0,   8'hBB, 1'b0); send(8'hBB);
      push_write(1,   8'hCC, 1'b1); send(8'hCC);
      check_drained("wrap");
   endtask

   task automatic test_bad_addr();
      send(8'hA5); send(8'h01); send(8'h40);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_addr: got err=%b busy=%b expected err=1 busy=0", err, busy);
      end
      send(8'h02); send(8'h11);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_addr_trailing: got err=%b busy=%b expected err=1 busy=0", err, busy);
      end
      send(8'hA5);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear_on_start: got %b expected 0", err);
      end
      send(8'h00); send(8'h00); send(8'h00);
      push_write(0, 8'h5A, 1'b1); send(8'h5A);
      check_drained("bad_addr");
   endtask

   task automatic test_gaps();
      send(8'h00); send(8'hFF);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL garbage_ignored: got busy=%b err=%b expected 0 0", busy, err);
      end
      send(8'hA5); send(8'h00); send(8'h10); send(8'h02);
      push_write(16, 8'hD1, 1'b0); send(8'hD1);
      for (int g = 0; g < 3; g++) drive_cycle(1'b0, 8'hA5, 1'b0);
      checks++;
      if (mem_addr !== 9'd16 || mem_data !== 8'hD1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gap_hold: got addr=%0d data=%h busy=%b expected 16 d1 1", mem_addr, mem_data, busy);
      end
      push_write(17, 8'hD2, 1'b0); send(8'hD2);
      for (int g = 0; g < 3; g++) drive_cycle(1'b0, 8'h00, 1'b0);
      push_write(18, 8'hD3, 1'b1); send(8'hD3);
      check_drained("gaps");
   endtask

   task automatic test_abort();
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_err0: got %b expected 0", err);
      end
      send(8'hA5); send(8'h00); send(8'h20); send(8'h09);
      for (int i = 0; i < 4; i++) begin
         push_write(32 + i, 8'(8'h60 + i), 1'b0);
         send(8'(8'h60 + i));
      end
      drive_cycle(1'b1, 8'h55, 1'b1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_frame: got err=%b busy=%b expected err=1 busy=0", err, busy);
      end
      send(8'h77);
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_err1: got err=%b busy=%b expected err=1 busy=0", err, busy);
      end
      send(8'hA5); send(8'h00); send(8'h30); send(8'h00);
      drive_cycle(1'b1, 8'h99, 1'b1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_last_byte: got err=%b busy=%b expected err=1 busy=0", err, busy);
      end
      check_drained("abort");
   endtask

   task automatic test_reset_mid();
      send(8'hA5); send(8'h00); send(8'h40); send(8'h05);
      push_write(64, 8'hE0, 1'b0); send(8'hE0);
      push_write(65, 8'hE1, 1'b0); send(8'hE1);
      rx_valid = 1'b1;
      rx_data  = 8'hE2;
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 9'd0 || mem_data !== 8'd0 || mem_we !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got addr=%0d data=%h we=%b done=%b err=%b busy=%b rdy=%b expected all 0",
                  mem_addr, mem_data, mem_we, done, err, busy, rx_ready);
      end
      drive_cycle(1'b1, 8'hE2, 1'b0);
      drive_cycle(1'b1, 8'hE3, 1'b0);
      reset = 1'b1;
      drive_cycle(1'b0, 8'h00, 1'b0);
      send(8'hA5); send(8'h00); send(8'hA0); send(8'hFF);
      for (int i = 0; i < 256; i++) begin
         push_write((160 + i) % 320, 8'(i * 7 + 3), (i == 255));
         send(8'(i * 7 + 3));
      end
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL full_frame_end: got busy=%b err=%b expected 0 0", busy, err);
      end
      check_drained("reset_mid");
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      exp_pending = 1'b0;
      reset       = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      abort       = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_bad_addr();
      test_gaps();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Sequencer that programs the weight/delay memory (M words x 8 bits) from a byte stream on the chip input pins.
- Parses a framed write command, drives the memory's write port (address, data, write-enable), auto-increments the address with wrap-around, and reports completion or error.
- Sits between the input-pin byte interface and the memory instance; it is the only writer of that memory.

Parameters:
- M, 320, number of memory words; address width AW = $clog2(M) (9 for default).
- N, 8, memory word width; fixed at 8 (one stream byte = one word); any other value is unsupported.
- START_CODE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader can accept a byte; a byte is accepted when rx_valid && rx_ready at posedge clk.
- abort  input  1  synchronous abort of the current frame.
- mem_addr  output  AW  memory write address (registered).
- mem_data  output  N  memory write data (registered).
- mem_we  output  1  memory write strobe, one cycle per word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, coincident with the last mem_we of a frame.
- err  output  1  sticky error flag; cleared by the next accepted START_CODE or by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_addr=0, mem_data=0, mem_we=0, done=0, err=0, busy=0, rx_ready=0; internal counters cleared. Memory contents are not touched; a partially loaded memory stays partially loaded.
- rx_ready: 1 in every state after reset deassertion; 0 while reset is asserted. Backpressure is never applied, so the source may stream one byte per cycle.
- Frame format: START_CODE, ADDR_HI, ADDR_LO, LEN, then LEN+1 data bytes (1..256 words).
  - Start address = {ADDR_HI, ADDR_LO}[AW-1:0]; the upper bits of ADDR_HI beyond AW are ignored.
- States:
  - IDLE: accepted byte == START_CODE -> ADDR_HI and err<=0; any other byte is ignored silently.
  - ADDR_HI: accept -> store the high byte -> ADDR_LO.
  - ADDR_LO: accept -> form the start address.
    - If start address >= M: err<=1 -> IDLE.
    - Otherwise -> LEN.
  - LEN: accept -> remaining <= LEN -> DATA.
  - DATA: each accepted byte issues one write.
    - After a byte accepted at edge t: at t+1, mem_we=1, mem_addr=current address, mem_data=byte.
    - The address register then increments; M-1 wraps to 0.
    - remaining decrements. The byte accepted with remaining==0 is the last: its write cycle also has done=1, and state -> IDLE.
- Latency: accepted data byte -> mem_we exactly 1 cycle. Back-to-back bytes give back-to-back writes at consecutive addresses.
- mem_we and done are 0 in every cycle except as specified. mem_addr and mem_data hold their last values when mem_we=0.
- Gaps (rx_valid=0) in any state: the state holds and no write is issued. There is no timeout.
- abort=1 at a posedge: state -> IDLE and no further writes; any byte presented that cycle is discarded; err<=1 if busy was 1, otherwise err is unchanged. abort has priority over byte acceptance.
- abort with a final-byte acceptance in the same cycle: the abort wins, the final write is not issued, and done is not pulsed.
- START_CODE inside a frame (ADDR_*, LEN, DATA) is treated as ordinary data; there is no resynchronisation.
- Wrap-around: a frame may cross M-1 -> 0. This is legal, no error.
- busy is a combinational decode of state != IDLE.

Test Plan:
- Basic load: stream A5,00,05,02,11,22,33 back-to-back -> writes (5,11),(6,22),(7,33) on 3 consecutive cycles, each 1 cycle after acceptance; done high with the (7,33) write; busy low the next cycle; err=0.
- Wrap: A5,01,3F,02,AA,BB,CC with M=320 -> writes at 319, 0, 1 with AA, BB, CC; done with the write at addr 1.
- Bad address: A5,01,40,... (320) -> err=1, no mem_we, state returns to IDLE. A following A5,00,00,00,5A -> err clears on the A5, then one write (0,5A) with done.
- Gaps and garbage: bytes 00,FF before A5 produce no effect; insert 3-cycle rx_valid=0 gaps between data bytes -> writes occur only 1 cycle after each accepted byte; addresses stay contiguous.
- Abort: frame LEN=09 aborted after 4 data bytes -> exactly 4 writes, no done, err=1, busy=0 next cycle; abort while IDLE -> err unchanged.
- Reset mid-frame: assert reset during DATA (asynchronously, mid-cycle) -> all outputs go to their reset values immediately, no further writes; after release, a fresh full 256-byte frame (LEN=FF) writes 256 consecutive words correctly with done on the last.
